// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, opcodes and state types for the calculator input parser
package calc_pkg;

  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_MAX_DIGITS = 4;

  // key[4] set means operator key; key[3] must then be clear for a valid operator
  localparam logic       KEY_OP_PREFIX = 1'b1;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_EQ  = 3'd4;
  localparam logic [2:0] OP_AC  = 3'd5;
  localparam logic [2:0] OP_NEG = 3'd6;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_DIV = 2'd3
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_ENTRY_A,
    ST_OP_PENDING,
    ST_ENTRY_B,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_RESULT
  } state_t;

  // Commands understood by each operand register
  typedef enum logic [2:0] {
    OPR_NOP,
    OPR_CLEAR,
    OPR_CLEAR_NEG,
    OPR_SET_DIGIT,
    OPR_APPEND,
    OPR_TOGGLE,
    OPR_LOAD
  } opr_cmd_t;

endpackage

// File: rtl/calc_input_parser_if.sv
// rtl/calc_input_parser_if.sv - key, request, result and display signals of the input parser
interface calc_input_parser_if #(
  parameter int WIDTH = 16
);
  logic [4:0]       i_key_data;
  logic             i_key_valid;
  logic             o_key_ready;
  logic [WIDTH-1:0] o_req_a;
  logic [WIDTH-1:0] o_req_b;
  logic [1:0]       o_req_op;
  logic             o_req_valid;
  logic             i_req_ready;
  logic [WIDTH-1:0] i_res_data;
  logic             i_res_err;
  logic             i_res_valid;
  logic [WIDTH-1:0] o_disp_value;
  logic             o_error;

  // Parser side
  modport master (
    input  i_key_data, i_key_valid, i_req_ready, i_res_data, i_res_err, i_res_valid,
    output o_key_ready, o_req_a, o_req_b, o_req_op, o_req_valid, o_disp_value, o_error
  );

  // Keypad / arithmetic unit / display side
  modport slave (
    output i_key_data, i_key_valid, i_req_ready, i_res_data, i_res_err, i_res_valid,
    input  o_key_ready, o_req_a, o_req_b, o_req_op, o_req_valid, o_disp_value, o_error
  );
endinterface

// File: rtl/operand_reg.sv
// rtl/operand_reg.sv - sign/magnitude operand with decimal digit entry and two's complement view
module operand_reg
  import calc_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  opr_cmd_t         cmd,
  input  logic [3:0]       digit,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [WIDTH-1:0] mag_q, mag_d, appended;
  logic             sign_q, sign_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // x10 via shifts keeps the multiplier out of the datapath
  assign appended = (mag_q << 3) + (mag_q << 1) + WIDTH'(digit);
  // negative zero naturally comes out as zero
  assign value = sign_q ? -mag_q : mag_q;

  // next operand contents for the requested command
  always_comb begin
    mag_d  = mag_q;
    sign_d = sign_q;
    cnt_d  = cnt_q;
    case (cmd)
      OPR_CLEAR: begin
        mag_d = '0; sign_d = 1'b0; cnt_d = '0;
      end
      OPR_CLEAR_NEG: begin
        mag_d = '0; sign_d = 1'b1; cnt_d = '0;
      end
      OPR_SET_DIGIT: begin
        mag_d  = WIDTH'(digit);
        sign_d = 1'b0;
        cnt_d  = CW'(digit != 4'd0);
      end
      OPR_APPEND: begin
        // digits beyond the limit are dropped; leading zeros do not count
        if (cnt_q != CW'(MAX_DIGITS)) begin
          mag_d = appended;
          if (appended != '0) cnt_d = cnt_q + 1'b1;
        end
      end
      OPR_TOGGLE: sign_d = ~sign_q;
      OPR_LOAD: begin
        // magnitude is unsigned, so the most negative value survives the round trip
        sign_d = load_val[WIDTH-1];
        mag_d  = load_val[WIDTH-1] ? -load_val : load_val;
        cnt_d  = '0;
      end
      default: ;
    endcase
  end

  // operand state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q  <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mag_q  <= mag_d;
      sign_q <= sign_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/calc_input_parser.sv
// rtl/calc_input_parser.sv - keypad-driven operand/operator sequencer feeding the arithmetic unit
module calc_input_parser
  import calc_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS
) (
  input logic                 clk,
  input logic                 rst_n,
  calc_input_parser_if.master bus
);
  state_t           state_q, state_d;
  alu_op_t          op_q, op_d, chain_op_q, chain_op_d;
  logic             chained_q, chained_d;
  logic             error_q, error_d;
  opr_cmd_t         a_cmd, b_cmd;
  logic [WIDTH-1:0] a_val, b_val;

  logic [4:0] key;
  logic [2:0] opc;
  logic       key_fire, is_digit, is_op, is_arith, is_eq, is_ac, is_neg;

  assign key      = bus.i_key_data;
  assign opc      = key[2:0];
  assign is_digit = (key[4] != KEY_OP_PREFIX) && (key[3:0] <= 4'd9);
  assign is_op    = (key[4] == KEY_OP_PREFIX) && !key[3];
  assign is_arith = is_op && (opc <= OP_DIV);
  assign is_eq    = is_op && (opc == OP_EQ);
  assign is_ac    = is_op && (opc == OP_AC);
  assign is_neg   = is_op && (opc == OP_NEG);

  assign bus.o_key_ready  = (state_q != ST_ISSUE) && (state_q != ST_WAIT_RES);
  assign key_fire         = bus.i_key_valid && bus.o_key_ready;
  assign bus.o_req_valid  = (state_q == ST_ISSUE);
  assign bus.o_req_a      = a_val;
  assign bus.o_req_b      = b_val;
  assign bus.o_req_op     = op_q;
  assign bus.o_disp_value = (state_q == ST_ENTRY_B) ? b_val : a_val;
  assign bus.o_error      = error_q;

  operand_reg #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_opr_a (
    .clk(clk), .rst_n(rst_n), .cmd(a_cmd), .digit(key[3:0]),
    .load_val(bus.i_res_data), .value(a_val)
  );

  operand_reg #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_opr_b (
    .clk(clk), .rst_n(rst_n), .cmd(b_cmd), .digit(key[3:0]),
    .load_val(bus.i_res_data), .value(b_val)
  );

  // next state, operator bookkeeping and operand commands
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    chain_op_d = chain_op_q;
    chained_d  = chained_q;
    error_d    = error_q;
    a_cmd      = OPR_NOP;
    b_cmd      = OPR_NOP;
    if (key_fire) begin
      if (is_ac) begin
        state_d    = ST_ENTRY_A;
        op_d       = ALU_ADD;
        chain_op_d = ALU_ADD;
        chained_d  = 1'b0;
        error_d    = 1'b0;
        a_cmd      = OPR_CLEAR;
        b_cmd      = OPR_CLEAR;
      end else if (!error_q) begin
        case (state_q)
          ST_ENTRY_A: begin
            if (is_digit) a_cmd = OPR_APPEND;
            else if (is_neg) a_cmd = OPR_TOGGLE;
            else if (is_arith) begin
              op_d    = alu_op_t'(opc[1:0]);
              state_d = ST_OP_PENDING;
            end
          end
          ST_OP_PENDING: begin
            if (is_digit) begin
              b_cmd   = OPR_SET_DIGIT;
              state_d = ST_ENTRY_B;
            end else if (is_neg) begin
              b_cmd   = OPR_CLEAR_NEG;
              state_d = ST_ENTRY_B;
            end else if (is_arith) op_d = alu_op_t'(opc[1:0]);
          end
          ST_ENTRY_B: begin
            if (is_digit) b_cmd = OPR_APPEND;
            else if (is_neg) b_cmd = OPR_TOGGLE;
            else if (is_eq) state_d = ST_ISSUE;
            else if (is_arith) begin
              chain_op_d = alu_op_t'(opc[1:0]);
              chained_d  = 1'b1;
              state_d    = ST_ISSUE;
            end
          end
          ST_RESULT: begin
            if (is_digit) begin
              a_cmd   = OPR_SET_DIGIT;
              state_d = ST_ENTRY_A;
            end else if (is_neg) a_cmd = OPR_TOGGLE;
            else if (is_arith) begin
              op_d    = alu_op_t'(opc[1:0]);
              state_d = ST_OP_PENDING;
            end
          end
          default: ;
        endcase
      end
    end
    case (state_q)
      ST_ISSUE: if (bus.i_req_ready) state_d = ST_WAIT_RES;
      ST_WAIT_RES: begin
        if (bus.i_res_valid) begin
          a_cmd   = OPR_LOAD;
          error_d = bus.i_res_err;
          if (chained_q) begin
            op_d      = chain_op_q;
            chained_d = 1'b0;
            b_cmd     = OPR_CLEAR;
            state_d   = ST_OP_PENDING;
          end else begin
            state_d = ST_RESULT;
          end
        end
      end
      default: ;
    endcase
  end

  // control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ENTRY_A;
      op_q       <= ALU_ADD;
      chain_op_q <= ALU_ADD;
      chained_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      chain_op_q <= chain_op_d;
      chained_q  <= chained_d;
      error_q    <= error_d;
    end
  end
endmodule

// File: tb/tb_calc_input_parser.sv
// tb/tb_calc_input_parser.sv - directed table-driven bench for the calculator input parser
module tb_calc_input_parser;
  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_SUB = 5'h11;
  localparam logic [4:0] K_MUL = 5'h12;
  localparam logic [4:0] K_EQ  = 5'h14;
  localparam logic [4:0] K_AC  = 5'h15;
  localparam logic [4:0] K_NEG = 5'h16;

  typedef struct {
    logic        is_res;
    logic [15:0] data;
    logic        err;
    logic [15:0] e_disp;
    logic        e_err;
    logic        e_rv;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [1:0]  e_op;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  calc_input_parser_if #(.WIDTH(16)) bus ();

  calc_input_parser #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic k(input logic [4:0] key, input logic [15:0] disp, input logic e_err = 1'b0);
    vecs.push_back('{1'b0, {11'd0, key}, 1'b0, disp, e_err, 1'b0, 16'd0, 16'd0, 2'd0});
  endtask

  task automatic kq(input logic [4:0] key, input logic [15:0] disp,
                    input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    vecs.push_back('{1'b0, {11'd0, key}, 1'b0, disp, 1'b0, 1'b1, a, b, op});
  endtask

  task automatic r(input logic [15:0] data, input logic err, input logic [15:0] disp);
    vecs.push_back('{1'b1, data, err, disp, err, 1'b0, 16'd0, 16'd0, 2'd0});
  endtask

  task automatic send_key(input logic [4:0] key);
    int n;
    @(negedge clk);
    bus.i_key_data  = key;
    bus.i_key_valid = 1'b1;
    n = 0;
    while (!bus.o_key_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("key_ready_timeout", 32'(bus.o_key_ready), 32'd1);
    @(posedge clk);
    #1 bus.i_key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_res(input logic [15:0] data, input logic err);
    @(negedge clk);
    if (bus.o_req_valid) begin
      bus.i_req_ready = 1'b1;
      @(posedge clk);
      #1 bus.i_req_ready = 1'b0;
      @(negedge clk);
    end
    bus.i_res_data  = data;
    bus.i_res_err   = err;
    bus.i_res_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_res_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.i_key_data  = '0;
    bus.i_key_valid = 1'b0;
    bus.i_req_ready = 1'b0;
    bus.i_res_data  = '0;
    bus.i_res_err   = 1'b0;
    bus.i_res_valid = 1'b0;

    // basic request and result
    k(5'd1, 16'd1); k(5'd2, 16'd12); k(K_ADD, 16'd12); k(5'd3, 16'd3); k(5'd4, 16'd34);
    kq(K_EQ, 16'd12, 16'd12, 16'd34, 2'd0); r(16'd46, 1'b0, 16'd46);
    // chained operation starting from RESULT
    k(5'd5, 16'd5); k(K_MUL, 16'd5); k(5'd6, 16'd6);
    kq(K_SUB, 16'd5, 16'd5, 16'd6, 2'd2); r(16'd30, 1'b0, 16'd30);
    k(5'd2, 16'd2); kq(K_EQ, 16'd30, 16'd30, 16'd2, 2'd1); r(16'd28, 1'b0, 16'd28);
    // digit limit and leading zeros
    k(K_AC, 16'd0); k(5'd1, 16'd1); k(5'd2, 16'd12); k(5'd3, 16'd123); k(5'd4, 16'd1234);
    k(5'd5, 16'd1234);
    k(K_AC, 16'd0); k(5'd0, 16'd0); k(5'd0, 16'd0); k(5'd7, 16'd7); k(5'd8, 16'd78);
    k(5'd9, 16'd789); k(5'd1, 16'd7891); k(5'd2, 16'd7891);
    // unused codes and EQ in ENTRY_A are ignored
    k(5'h0A, 16'd7891); k(5'h17, 16'd7891); k(5'h1F, 16'd7891); k(K_EQ, 16'd7891);
    // signs and most-negative result
    k(K_AC, 16'd0); k(5'd9, 16'd9); k(K_NEG, 16'hFFF7); k(K_SUB, 16'hFFF7); k(5'd3, 16'd3);
    k(K_NEG, 16'hFFFD); kq(K_EQ, 16'hFFF7, 16'hFFF7, 16'hFFFD, 2'd1);
    r(16'h8000, 1'b0, 16'h8000); k(K_NEG, 16'h8000); k(5'd3, 16'd3);
    // op replacement, NEG in OP_PENDING, then error stickiness
    k(K_AC, 16'd0); k(5'd5, 16'd5); k(K_ADD, 16'd5); k(K_MUL, 16'd5); k(K_NEG, 16'd0);
    k(5'd3, 16'hFFFD); kq(K_EQ, 16'd5, 16'd5, 16'hFFFD, 2'd2);
    r(16'h1234, 1'b1, 16'h1234); k(5'd4, 16'h1234, 1'b1); k(K_ADD, 16'h1234, 1'b1);
    k(K_EQ, 16'h1234, 1'b1); k(K_AC, 16'd0);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_disp", 32'(bus.o_disp_value), 32'd0);
    check("rst_err", 32'(bus.o_error), 32'd0);
    check("rst_rv", 32'(bus.o_req_valid), 32'd0);
    check("rst_ready", 32'(bus.o_key_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_res) send_res(vecs[i].data, vecs[i].err);
      else send_key(vecs[i].data[4:0]);
      check($sformatf("v%0d_disp", i), 32'(bus.o_disp_value), 32'(vecs[i].e_disp));
      check($sformatf("v%0d_err", i), 32'(bus.o_error), 32'(vecs[i].e_err));
      check($sformatf("v%0d_rv", i), 32'(bus.o_req_valid), 32'(vecs[i].e_rv));
      check($sformatf("v%0d_ready", i), 32'(bus.o_key_ready), 32'(!vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        check($sformatf("v%0d_a", i), 32'(bus.o_req_a), 32'(vecs[i].e_a));
        check($sformatf("v%0d_b", i), 32'(bus.o_req_b), 32'(vecs[i].e_b));
        check($sformatf("v%0d_op", i), 32'(bus.o_req_op), 32'(vecs[i].e_op));
      end
    end

    // backpressure: request held, AC held off until the result returns
    send_key(5'd1); send_key(K_ADD); send_key(5'd2); send_key(K_EQ);
    bus.i_key_data  = K_AC;
    bus.i_key_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_rv", c), 32'(bus.o_req_valid), 32'd1);
      check($sformatf("bp%0d_a", c), 32'(bus.o_req_a), 32'd1);
      check($sformatf("bp%0d_b", c), 32'(bus.o_req_b), 32'd2);
      check($sformatf("bp%0d_op", c), 32'(bus.o_req_op), 32'd0);
      check($sformatf("bp%0d_ready", c), 32'(bus.o_key_ready), 32'd0);
    end
    bus.i_req_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_req_ready = 1'b0;
    @(negedge clk);
    check("bp_wait_rv", 32'(bus.o_req_valid), 32'd0);
    check("bp_wait_ready", 32'(bus.o_key_ready), 32'd0);
    bus.i_res_data  = 16'd3;
    bus.i_res_err   = 1'b0;
    bus.i_res_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_res_valid = 1'b0;
    @(negedge clk);
    check("bp_res_disp", 32'(bus.o_disp_value), 32'd3);
    check("bp_res_ready", 32'(bus.o_key_ready), 32'd1);
    @(posedge clk);
    #1 bus.i_key_valid = 1'b0;
    @(negedge clk);
    check("bp_ac_disp", 32'(bus.o_disp_value), 32'd0);

    // asynchronous reset in the middle of a request
    send_key(5'd4); send_key(K_ADD); send_key(5'd5); send_key(K_EQ);
    check("mid_rv_before", 32'(bus.o_req_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rv", 32'(bus.o_req_valid), 32'd0);
    check("mid_rst_disp", 32'(bus.o_disp_value), 32'd0);
    check("mid_rst_err", 32'(bus.o_error), 32'd0);
    check("mid_rst_ready", 32'(bus.o_key_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_res_data  = 16'd99;
    bus.i_res_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_res_valid = 1'b0;
    @(negedge clk);
    check("stray_res_disp", 32'(bus.o_disp_value), 32'd0);
    send_key(5'd6);
    check("after_stray_disp", 32'(bus.o_disp_value), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
